tt_stim_sequencer: RTL and testbench

Parametrised, synthesisable stimulus/response sequencer for the tiny-tapeout user modules. It replaces a fixed "hold switches, release after N ns" bench with a programmable table of switch vectors, dwell times and masked expected outputs. It drives the DUT's switch inputs, checks `io_out` at the end of each step, and reports pass/fail with error counts, in simulation and on FPGA bring-up boards alike.

---
 rtl/tt_stim_pkg.sv | 17 +
 rtl/tt_stim_step_table.sv | 50 +++++
 rtl/tt_stim_sequencer.sv | 153 +++++++++++++++
 tb/tb_tt_stim_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_stim_pkg.sv
// Shared types and helpers for the tiny-tapeout stimulus sequencer.
package tt_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A dwell of 0 behaves like 1, so both reload the counter with 0.
  function automatic logic [31:0] dwell_reload(
    input logic [31:0] d
  );
    return (d == 32'd0) ? 32'd0 : d - 32'd1;
  endfunction

endpackage

// File: rtl/tt_stim_step_table.sv
// Step table: one write port, one combinational read port, sync reset.
module tt_stim_step_table #(
  parameter int NUM_SW    = 7,
  parameter int OUT_W     = 8,
  parameter int NUM_STEPS = 8,
  parameter int STEP_AW   = $clog2(NUM_STEPS),
  parameter int DELAY_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [STEP_AW-1:0] waddr,
  input  logic [NUM_SW-1:0]  wsw,
  input  logic [DELAY_W-1:0] wdelay,
  input  logic [OUT_W-1:0]   wexpect,
  input  logic [OUT_W-1:0]   wmask,
  input  logic [STEP_AW-1:0] raddr,
  output logic [NUM_SW-1:0]  rsw,
  output logic [DELAY_W-1:0] rdelay,
  output logic [OUT_W-1:0]   rexpect,
  output logic [OUT_W-1:0]   rmask
);

  logic [NUM_SW-1:0]  sw_q     [NUM_STEPS];
  logic [DELAY_W-1:0] delay_q  [NUM_STEPS];
  logic [OUT_W-1:0]   expect_q [NUM_STEPS];
  logic [OUT_W-1:0]   mask_q   [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        sw_q[i]     <= '0;
        delay_q[i]  <= '0;
        expect_q[i] <= '0;
        mask_q[i]   <= '0;
      end
    end else if (we) begin
      sw_q[waddr]     <= wsw;
      delay_q[waddr]  <= wdelay;
      expect_q[waddr] <= wexpect;
      mask_q[waddr]   <= wmask;
    end
  end

  assign rsw     = sw_q[raddr];
  assign rdelay  = delay_q[raddr];
  assign rexpect = expect_q[raddr];
  assign rmask   = mask_q[raddr];

endmodule

// File: rtl/tt_stim_sequencer.sv
// Programmable switch-vector sequencer with masked output checking.
module tt_stim_sequencer
  import tt_stim_pkg::*;
#(
  parameter int NUM_SW    = 7,
  parameter int OUT_W     = 8,
  parameter int NUM_STEPS = 8,
  parameter int STEP_AW   = $clog2(NUM_STEPS),
  parameter int DELAY_W   = 16,
  parameter int ERR_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [STEP_AW-1:0] cfg_addr,
  input  logic [NUM_SW-1:0]  cfg_sw,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [OUT_W-1:0]   cfg_expect,
  input  logic [OUT_W-1:0]   cfg_mask,
  input  logic [STEP_AW-1:0] last_step,
  input  logic               loop_en,
  input  logic               start,
  input  logic               abort,
  input  logic [OUT_W-1:0]   dut_out,
  output logic [NUM_SW-1:0]  sw_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [STEP_AW-1:0] step_idx,
  output logic [ERR_W-1:0]   err_count,
  output logic               first_err_valid,
  output logic [STEP_AW-1:0] first_err_step
);

  state_t             state;
  logic [DELAY_W-1:0] cnt;
  logic [OUT_W-1:0]   cur_expect;
  logic [OUT_W-1:0]   cur_mask;

  logic               table_we;
  logic               more;
  logic               mismatch;
  logic [STEP_AW-1:0] rd_addr;
  logic [NUM_SW-1:0]  rd_sw;
  logic [DELAY_W-1:0] rd_delay;
  logic [OUT_W-1:0]   rd_expect;
  logic [OUT_W-1:0]   rd_mask;
  logic [DELAY_W-1:0] reload;
  logic [ERR_W-1:0]   err_next;

  assign table_we = cfg_we && (state != RUN);
  assign more     = step_idx < last_step;

  // The read port always points at whatever step loads on the next edge.
  assign rd_addr = (state == RUN && more)
                 ? step_idx + STEP_AW'(1) : '0;

  assign reload   = DELAY_W'(dwell_reload(32'(rd_delay)));
  assign mismatch = |((dut_out ^ cur_expect) & cur_mask);
  assign err_next = (err_count == '1)
                  ? err_count : err_count + ERR_W'(1);

  tt_stim_step_table #(
    .NUM_SW    (NUM_SW),
    .OUT_W     (OUT_W),
    .NUM_STEPS (NUM_STEPS),
    .STEP_AW   (STEP_AW),
    .DELAY_W   (DELAY_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (table_we),
    .waddr   (cfg_addr),
    .wsw     (cfg_sw),
    .wdelay  (cfg_delay),
    .wexpect (cfg_expect),
    .wmask   (cfg_mask),
    .raddr   (rd_addr),
    .rsw     (rd_sw),
    .rdelay  (rd_delay),
    .rexpect (rd_expect),
    .rmask   (rd_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sw_out          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      step_idx        <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_step  <= '0;
      cnt             <= '0;
      cur_expect      <= '0;
      cur_mask        <= '0;
    end else if (abort) begin
      state  <= IDLE;
      sw_out <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_step  <= '0;
            step_idx        <= '0;
            sw_out          <= rd_sw;
            cnt             <= reload;
            cur_expect      <= rd_expect;
            cur_mask        <= rd_mask;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - DELAY_W'(1);
          end else begin
            if (mismatch) begin
              err_count <= err_next;
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_step  <= step_idx;
              end
            end
            if (more || loop_en) begin
              step_idx   <= rd_addr;
              sw_out     <= rd_sw;
              cnt        <= reload;
              cur_expect <= rd_expect;
              cur_mask   <= rd_mask;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mismatch ? err_next : err_count) == '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_stim_sequencer.sv
// Directed bench for tt_stim_sequencer with a step-level reference model.
module tb_tt_stim_sequencer;

  localparam int SW = 7;
  localparam int OW = 8;
  localparam int NS = 8;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int EW = 2;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [SW-1:0] cfg_sw;
  logic [DW-1:0] cfg_delay;
  logic [OW-1:0] cfg_expect;
  logic [OW-1:0] cfg_mask;
  logic [AW-1:0] last_step;
  logic          loop_en;
  logic          start;
  logic          abort;
  logic [OW-1:0] dut_out;
  logic [SW-1:0] sw_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] step_idx;
  logic [EW-1:0] err_count;
  logic          first_err_valid;
  logic [AW-1:0] first_err_step;

  always #5 clk = ~clk;

  tt_stim_sequencer #(
    .NUM_SW(SW), .OUT_W(OW), .NUM_STEPS(NS),
    .STEP_AW(AW), .DELAY_W(DW), .ERR_W(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sw(cfg_sw), .cfg_delay(cfg_delay),
    .cfg_expect(cfg_expect), .cfg_mask(cfg_mask),
    .last_step(last_step), .loop_en(loop_en),
    .start(start), .abort(abort), .dut_out(dut_out),
    .sw_out(sw_out), .busy(busy), .done(done),
    .pass(pass), .step_idx(step_idx),
    .err_count(err_count),
    .first_err_valid(first_err_valid),
    .first_err_step(first_err_step)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: tracks time spent in each step and applies the rules.
  int t_sw[NS], t_dl[NS], t_ex[NS], t_mk[NS];
  bit m_valid = 0, m_run = 0, m_done = 0, m_fev = 0;
  int m_sw = 0, m_step = 0, m_el = 0, m_err = 0, m_fes = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_valid = 1; m_run = 0; m_done = 0; m_fev = 0;
      m_sw = 0; m_step = 0; m_el = 0; m_err = 0; m_fes = 0;
      for (int i = 0; i < NS; i++) begin
        t_sw[i] = 0; t_dl[i] = 0; t_ex[i] = 0; t_mk[i] = 0;
      end
    end else if (abort) begin
      m_run = 0; m_done = 0; m_sw = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_err = 0; m_fev = 0; m_fes = 0;
        m_step = 0; m_sw = t_sw[0]; m_el = 1;
      end
      if (cfg_we) begin
        t_sw[cfg_addr] = cfg_sw;
        t_dl[cfg_addr] = cfg_delay;
        t_ex[cfg_addr] = cfg_expect;
        t_mk[cfg_addr] = cfg_mask;
      end
    end else begin
      if (m_el < ((t_dl[m_step] == 0) ? 1 : t_dl[m_step])) begin
        m_el++;
      end else begin
        if (((int'(dut_out) ^ t_ex[m_step]) & t_mk[m_step]) != 0) begin
          if (m_err < EMAX) m_err++;
          if (!m_fev) begin m_fev = 1; m_fes = m_step; end
        end
        if (m_step < int'(last_step)) begin
          m_step++; m_sw = t_sw[m_step]; m_el = 1;
        end else if (loop_en) begin
          m_step = 0; m_sw = t_sw[0]; m_el = 1;
        end else begin
          m_run = 0; m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_sw_out", sw_out, m_sw);
      check("m_busy", busy, m_run);
      check("m_done", done, m_done);
      check("m_pass", pass, m_done && m_err == 0);
      check("m_step_idx", step_idx, m_step);
      check("m_err_count", err_count, m_err);
      check("m_fe_valid", first_err_valid, m_fev);
      check("m_fe_step", first_err_step, m_fes);
    end
  end

  task automatic wr(input int a, input int s, input int d,
                    input int e, input int m);
    cfg_addr = AW'(a); cfg_sw = SW'(s); cfg_delay = DW'(d);
    cfg_expect = OW'(e); cfg_mask = OW'(m); cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int lat,
                           input string nm);
    while (!done && (cyc - t0) < 200) @(negedge clk);
    check(nm, cyc - t0, lat);
  endtask

  initial begin
    int t0;
    rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_sw = 0;
    cfg_delay = 0; cfg_expect = 0; cfg_mask = 0;
    last_step = 0; loop_en = 0; start = 0; abort = 0;
    dut_out = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_sw", sw_out, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);

    // Plain stimulus run: 5+10+1 cycles.
    wr(0, 0, 5, 0, 0); wr(1, 1, 10, 0, 0); wr(2, 1, 1, 0, 0);
    last_step = 2;
    go(); t0 = cyc;
    check("t1_sw0", sw_out, 0);
    repeat (4) @(negedge clk);
    check("t1_sw_hold", sw_out, 0);
    @(negedge clk);
    check("t1_sw1", sw_out, 1);
    wait_done(t0, 16, "t1_latency");
    check("t1_pass", pass, 1);

    // Single masked mismatch on step 1.
    wr(1, 1, 10, 'hA5, 'hFF);
    dut_out = 8'hA4;
    go(); t0 = cyc;
    wait_done(t0, 16, "t2_latency");
    check("t2_err", err_count, 1);
    check("t2_fes", first_err_step, 1);
    check("t2_pass", pass, 0);

    // Looping with a mismatch every step: saturation.
    dut_out = 8'hFF;
    for (int i = 0; i < 4; i++) wr(i, i, 1, 0, 'hFF);
    last_step = 3; loop_en = 1;
    go();
    repeat (20) @(negedge clk);
    check("t3_err_sat", err_count, 3);
    check("t3_fes", first_err_step, 0);
    check("t3_fev", first_err_valid, 1);
    check("t3_no_done", done, 0);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("t3_abort_busy", busy, 0);

    // Zero dwell, and a write attempted mid-run.
    loop_en = 0; dut_out = 0; last_step = 1;
    wr(0, 'h11, 0, 0, 0); wr(1, 'h22, 2, 0, 0);
    go(); t0 = cyc;
    check("t4_sw0", sw_out, 'h11);
    @(negedge clk);
    check("t4_sw1", sw_out, 'h22);
    wr(0, 'h7F, 9, 0, 0);
    wait_done(t0, 3, "t4_latency");
    go(); t0 = cyc;
    check("t4b_sw0", sw_out, 'h11);
    wait_done(t0, 3, "t4b_latency");

    // start together with abort mid-run.
    go(); @(negedge clk);
    start = 1'b1; abort = 1'b1; @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_sw", sw_out, 0);
    check("t5_done", done, 0);

    // Reset mid-run clears everything, table included.
    go(); @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("t6_sw", sw_out, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_step", step_idx, 0);
    check("t6_fev", first_err_valid, 0);
    last_step = 2;
    dut_out = 8'h5A;
    go(); t0 = cyc;
    check("t6_tbl_sw", sw_out, 0);
    wait_done(t0, 3, "t6_tbl_dwell");
    check("t6_pass", pass, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
